// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns core load/store requests into a
// held req/ack handshake, freezing the pipeline until the access completes.
module dmem_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        MisalignErr,
   output logic        TimeoutErr
);

   localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [7:0]  r_count;
   logic [31:0] r_readData;
   logic        r_misalign;
   logic        r_timeoutErr;

   logic        w_access;
   logic        w_aligned;
   logic        w_misaligned;
   logic        w_timeout;

   assign w_access     = MemRead | MemWrite;
   assign w_aligned    = w_access && (ALUResult[1:0] == 2'b00);
   assign w_misaligned = w_access && (ALUResult[1:0] != 2'b00);
   assign w_timeout    = (r_count == LP_TIMEOUT);

   assign ReadData    = r_readData;
   assign mem_we      = r_we;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign MisalignErr = r_misalign;
   assign TimeoutErr  = r_timeoutErr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Stall in IDLE is combinational so the core freezes in the capture cycle.
   always_comb begin
      w_next  = r_state;
      Stall   = 1'b0;
      mem_req = 1'b0;
      case (r_state)
         IDLE: begin
            Stall = w_aligned;
            if (w_aligned) begin
               w_next = REQ;
            end
         end
         REQ: begin
            Stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ack || w_timeout) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // An ack in the same cycle as the last allowed wait still wins over abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_count      <= '0;
         r_readData   <= '0;
         r_misalign   <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_misalign <= (r_state == IDLE) && w_misaligned;
         case (r_state)
            IDLE: begin
               if (w_aligned) begin
                  r_addr  <= ALUResult[31:2];
                  r_wdata <= WriteData;
                  r_we    <= MemWrite;
                  r_count <= '0;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  if (!r_we) begin
                     r_readData <= mem_rdata;
                  end
               end else if (w_timeout) begin
                  r_timeoutErr <= 1'b1;
                  r_readData   <= '0;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for mem_ack before abort (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MemWrite  input  1  core store request for the current memory-stage instruction.
REQ-005 SHALL have port MemRead  input  1  core load request for the current memory-stage instruction.
REQ-006 SHALL have port ALUResult  input  32  byte address from core.
REQ-007 SHALL have port WriteData  input  32  store data from core.
REQ-008 SHALL have port ReadData  output  32  registered load data to core.
REQ-009 SHALL have port Stall  output  1  core pipeline freeze while an access is outstanding.
REQ-010 SHALL have ports mem_req  output  1 / mem_we  output  1 / mem_addr  output  30 (word address) / mem_wdata  output  32, the memory request side.
REQ-011 SHALL have ports mem_ack  input  1 / mem_rdata  input  32, the memory response side.
REQ-012 SHALL have ports MisalignErr  output  1 (one-cycle pulse) and TimeoutErr  output  1 (sticky).

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE.
REQ-014 IDLE: if (MemRead|MemWrite) and ALUResult[1:0]==0, SHALL capture ALUResult[31:2], WriteData, MemWrite into registers, assert Stall combinationally in that same cycle, go to REQ.
REQ-015 IDLE: if MemRead and MemWrite both high, SHALL treat access as write.
REQ-016 IDLE: if request with ALUResult[1:0]!=0, SHALL issue no memory request, keep Stall=0, pulse MisalignErr high for the next cycle only, leave ReadData unchanged, stay IDLE.
REQ-017 REQ: SHALL drive mem_req=1, mem_we/mem_addr/mem_wdata from captured registers, held stable until mem_ack; Stall=1.
REQ-018 REQ with mem_ack=1: SHALL load ReadData<=mem_rdata on reads (unchanged on writes), drop mem_req next cycle, go to DONE.
REQ-019 mem_ack in the first REQ cycle SHALL be accepted (minimum access latency: request cycle + 1 REQ cycle + DONE = Stall high 2 cycles).
REQ-020 REQ: SHALL count wait cycles in an 8-bit counter cleared on REQ entry; when counter==TIMEOUT without mem_ack, SHALL set TimeoutErr, ReadData<=0, go to DONE.
REQ-021 DONE: SHALL drive Stall=0, mem_req=0 for exactly one cycle, then go to IDLE regardless of inputs.
REQ-022 mem_ack outside REQ SHALL be ignored.
REQ-023 Stall SHALL equal 1 in REQ, 0 in DONE, and in IDLE equal the aligned-request condition of REQ-014.
REQ-024 mem_req SHALL never be high in IDLE or DONE.

Reset
REQ-025 reset SHALL force state IDLE, ReadData=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, MisalignErr=0, TimeoutErr=0 at the next clk edge.
REQ-026 reset asserted during REQ SHALL abandon the access with no ReadData update; reset takes priority over mem_ack in the same cycle.
REQ-027 TimeoutErr SHALL clear only on reset.

Verification
REQ-028 Read, ALUResult=0x100, MemRead=1, mem_ack one cycle after mem_req with mem_rdata=0xCAFEF00D -> mem_addr=0x40, mem_we=0, Stall high 2 cycles, ReadData=0xCAFEF00D in DONE.
REQ-029 Write, ALUResult=0x204, WriteData=0x12345678, mem_ack after 5 wait cycles -> mem_we=1, mem_addr=0x81, mem_wdata=0x12345678 stable throughout, Stall high 7 cycles, ReadData unchanged.
REQ-030 MemRead=1, ALUResult=0x102 -> mem_req never asserted, Stall=0, MisalignErr high exactly one cycle.
REQ-031 TIMEOUT=4, read with mem_ack never asserted -> abort after 4 REQ wait cycles, TimeoutErr=1 and stays 1, ReadData=0, FSM returns IDLE via DONE.
REQ-032 reset during REQ coincident with mem_ack=1, mem_rdata=0xFFFFFFFF -> next cycle IDLE, mem_req=0, ReadData=0.
REQ-033 Back-to-back loads in consecutive instructions -> second request captured in the IDLE cycle after DONE, no lost or duplicated mem_req.
